grid_ram_arbiter: RTL
=====================

# grid_ram_arbiter

Sequencer and arbiter for port A of the 64-row × 60-bit snake grid RAM (two cascaded block RAMs, one-cycle read latency, no output register). It shares the single read/write port between two game-logic requesters: the snake builder and the food placer. It also owns a clear sequencer that zeroes every row after reset and on command. The display path keeps exclusive use of port B and is unaffected.

## Interface
Parameters:
- ADDR_W, 6, row address width
- DATA_W, 60, row width in bits
- ROWS, 64, number of rows walked by the clear sequencer
- SEED_ROW, 32, row written with SEED_DATA during a clear (used only with GRID_ARB_SEED_EN)
- SEED_DATA, 60'h7 << 28, initial snake pattern (used only with GRID_ARB_SEED_EN)

Ports:
- clk  in  1  system clock, the same clock as the grid RAM ports
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; requester 0 is the snake builder, requester 1 is the food placer
- we0 / we1  in  1  write (1) or read (0), qualified by reqN
- addr0 / addr1  in  ADDR_W  row address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access issued this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid on rdata (registered)
- rdata  out  DATA_W  pass-through of ram_rdata
- clear_start  in  1  single-cycle pulse that starts a full clear
- clear_busy  out  1  clear sequencer active
- ram_addr  out  ADDR_W  RAM port A address
- ram_we  out  1  RAM port A write enable
- ram_wdata  out  DATA_W  RAM port A write data
- ram_rdata  in  DATA_W  RAM port A read data

## Operation
- The FSM has two states: CLEAR and SERVE. Reset enters CLEAR with clr_ptr = 0.
- CLEAR state:
  - Each cycle: ram_we = 1, ram_addr = clr_ptr, ram_wdata = 0, then clr_ptr increments.
  - When clr_ptr = ROWS-1 has been written, the FSM moves to SERVE.
  - gnt0 and gnt1 are held at 0, so requests stall and are not dropped.
- SERVE state:
  - Exactly one access is made per cycle.
  - If only one reqN is high, it is granted.
  - If both are high, the requester not granted most recently wins (round robin). The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The granted requester's we/addr/wdata drive the RAM combinationally.
  - With no request: ram_we = 0, and ram_addr keeps its last value (registered hold).
- Handshake:
  - A requester holds reqN and its signals stable until it sees gntN = 1.
  - It may keep reqN high for back-to-back accesses and be granted every cycle when uncontested.
- Reads: rvalidN pulses for one cycle, exactly one cycle after a read grant to N. rdata is meaningful only while rvalidN is high. Writes produce no rvalid.
- clear_start:
  - In SERVE: enters CLEAR on the next cycle. An access granted in the same cycle still completes, and its rvalid still fires.
  - In CLEAR: restarts the walk at row 0.
- rst mid-clear or mid-access: aborts immediately, and any pending rvalid is suppressed.
- clr_ptr is ADDR_W+1 bits wide so that ROWS = 2^ADDR_W terminates without wrap. The RAM address uses the low ADDR_W bits.

## Timing
- Reset values: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, clear_busy = 1, ram_we = 1, ram_addr = 0, ram_wdata = 0.
- A clear takes exactly ROWS cycles. clear_busy falls on the cycle the FSM enters SERVE, which is ROWS cycles after rst is released.
- Grant latency is 0 cycles in SERVE (gnt is combinational from req). Read data latency is 1 cycle after grant.
- Maximum wait when contested is 1 cycle.
- No combinational path runs from ram_rdata to any output except rdata.

## Configuration
- GRID_ARB_SEED_EN defined:
  - The clear walk writes SEED_DATA instead of 0 when clr_ptr = SEED_ROW, so the game starts with a 3-segment snake.
  - SEED_ROW must be < ROWS.
- GRID_ARB_SEED_EN undefined:
  - Every row is written 0.
  - SEED_ROW and SEED_DATA are ignored and no comparator is built.

## Structure
- Package grid_pkg holds:
  - GRID_ADDR_W = 6, GRID_DATA_W = 60, GRID_ROWS = 64
  - the FSM state enum {ST_CLEAR, ST_SERVE}
- The builder, screen updater and this block all import grid_pkg.
- One sub-module, rr_arb2, contains the two-input round-robin grant logic and the last-grant pointer.
- The clear sequencer and the RAM mux stay in grid_ram_arbiter.

## Test plan
- Reset, then idle for 64 cycles: ram_we = 1 with addresses 0..63 and wdata 0 on consecutive cycles; clear_busy drops at cycle 64; gnt stays 0 throughout. With GRID_ARB_SEED_EN, row 32 receives 60'h7<<28.
- req0 = 1, read addr 5 in SERVE, with the RAM model returning 60'hABC: gnt0 = 1 in the same cycle, and rvalid0 = 1 with rdata = 60'hABC on the next cycle only.
- req0 and req1 both held high for 4 cycles: grants go 0, 1, 0, 1 and ram_addr alternates between addr0 and addr1.
- clear_start while req1 is reading addr 9: that read's rvalid1 still fires, a 64-cycle clear follows, and req1 is re-granted in the first SERVE cycle.
- clear_start at clr_ptr = 40: the next ram_addr is 0, and clear_busy stays high for 64 further cycles.
- rst asserted one cycle after a read grant: rvalid is 0 on the following cycle, and the clear restarts at row 0.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared definitions for the snake grid RAM: geometry and arbiter FSM states.
package grid_pkg;

  localparam int GRID_ADDR_W = 6;
  localparam int GRID_DATA_W = 60;
  localparam int GRID_ROWS   = 64;

  typedef enum logic {
    ST_CLEAR,
    ST_SERVE
  } grid_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted most recently wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 1 means requester 1 held the last grant, so requester 0 wins the first tie.
  logic r_last;

  always_comb begin
    o_gnt0 = i_en & i_req0 & (~i_req1 | r_last);
    o_gnt1 = i_en & i_req1 & (~i_req0 | ~r_last);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (o_gnt0) begin
      r_last <= 1'b0;
    end else if (o_gnt1) begin
      r_last <= 1'b1;
    end
  end

endmodule

// File: rtl/grid_ram_arbiter.sv
// Port-A sequencer for the snake grid RAM: clear walk after reset/command, then
// round-robin sharing between snake builder (0) and food placer (1).
// Optional GRID_ARB_SEED_EN: the clear walk writes SEED_DATA into SEED_ROW.
module grid_ram_arbiter
  import grid_pkg::*;
#(
  parameter int                ADDR_W    = GRID_ADDR_W,
  parameter int                DATA_W    = GRID_DATA_W,
  parameter int                ROWS      = GRID_ROWS,
  parameter int                SEED_ROW  = 32,
  parameter logic [DATA_W-1:0] SEED_DATA = 60'h7 << 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // One extra pointer bit lets ROWS = 2**ADDR_W finish without wrapping.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(ROWS - 1);

  grid_state_e       r_state;
  grid_state_e       w_state_nxt;
  logic [ADDR_W:0]   r_clr_ptr;
  logic [ADDR_W:0]   w_clr_ptr_nxt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] w_clr_data;

`ifdef GRID_ARB_SEED_EN
  localparam logic [ADDR_W:0] SEED_PTR = (ADDR_W+1)'(SEED_ROW);
  assign w_clr_data = (r_clr_ptr == SEED_PTR) ? SEED_DATA : '0;
`else
  assign w_clr_data = '0;
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ST_SERVE),
    .i_req0 (req0),
    .i_req1 (req1),
    .o_gnt0 (gnt0),
    .o_gnt1 (gnt1)
  );

  // NOTE: defaults assigned first so no path through this block infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        if (clear_start) begin
          w_clr_ptr_nxt = '0;
        end else if (r_clr_ptr == LAST_PTR) begin
          w_state_nxt   = ST_SERVE;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      ST_SERVE: begin
        if (clear_start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = r_addr_hold;
    ram_wdata = '0;
    if (r_state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = r_clr_ptr[ADDR_W-1:0];
      ram_wdata = w_clr_data;
    end else if (gnt0) begin
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clr_ptr   <= '0;
      r_addr_hold <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_ptr   <= w_clr_ptr_nxt;
      r_addr_hold <= ram_addr;
      r_rvalid0   <= gnt0 & ~we0;
      r_rvalid1   <= gnt1 & ~we1;
    end
  end

  assign rvalid0    = r_rvalid0;
  assign rvalid1    = r_rvalid1;
  assign rdata      = ram_rdata;
  assign clear_busy = (r_state == ST_CLEAR);

endmodule
